if_fetch_ctrl: RTL and testbench

Fetch-stage sequencer that owns the PC and drives a request/grant/response handshake to a variable-latency instruction memory. Handles redirects (exception, jump, branch) by squashing any in-flight fetch and presents instructions to ID under the StallF back-pressure. Sits between the PC/redirect logic of IF and the instruction memory port; replaces the fixed single-cycle fetch path.

---
 rtl/if_pkg.sv | 29 ++
 rtl/if_fetch_ctrl_if.sv | 29 ++
 rtl/if_skid_buf.sv | 42 ++++
 rtl/if_fetch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding, redirect-source priority
// and the default reset PC.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD
  } fetch_state_e;

  // Encoded so that a larger value wins: exc > jump > branch.
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2,
    REDIR_EXC    = 2'd3
  } redir_src_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic redir_src_e redir_winner(input logic exc, input logic jump,
                                              input logic branch);
    if (exc) return REDIR_EXC;
    if (jump) return REDIR_JUMP;
    if (branch) return REDIR_BRANCH;
    return REDIR_NONE;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/grant/response bundle. master = fetch sequencer,
// slave = memory.
interface if_fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {inst, pc} skid buffer. flush beats load beats drain; load and drain in the
// same cycle replaces the held entry.
module if_skid_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_inst,
  input  logic [WIDTH-1:0] in_pc,
  output logic             full,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc
);

  logic             full_q;
  logic [WIDTH-1:0] inst_q;
  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b1;
      inst_q <= in_inst;
      pc_q   <= in_pc;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  assign full     = full_q;
  assign out_inst = inst_q;
  assign out_pc   = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs a one-outstanding req/gnt/rvalid handshake to
// instruction memory, squashes on redirect. Define IF_PERF_CNT_EN for perf counters.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_pc,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_pc,
  if_fetch_ctrl_if.master  imem,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] pc_add_4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_discard_cnt
`endif
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             inst_valid_q, inst_valid_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;

  redir_src_e       redir_src;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             req;
  logic             resp_valid;
  logic             resp_drop;
  logic             load_out;
  logic             skid_full;
  logic             skid_load;
  logic             skid_drain;
  logic [WIDTH-1:0] skid_inst;
  logic [WIDTH-1:0] skid_pc;

  assign redir_src = redir_winner(exc_valid, jump_valid, branch_valid);
  assign redirect  = (redir_src != REDIR_NONE);

  always_comb begin
    case (redir_src)
      REDIR_EXC:    redirect_pc = exc_pc;
      REDIR_JUMP:   redirect_pc = jump_pc;
      REDIR_BRANCH: redirect_pc = branch_pc;
      default:      redirect_pc = pc_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req        = 1'b0;
    resp_valid = 1'b0;
    resp_drop  = 1'b0;
    case (state_q)
      S_REQ: begin
        // A full skid means nowhere to put another response, so hold off.
        req = !skid_full;
        if (req && imem.imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + WIDTH'(32'd4);
          state_d  = redirect ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d    = S_REQ;
          resp_valid = !redirect;
          resp_drop  = redirect;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem.imem_rvalid) begin
          state_d   = S_REQ;
          resp_drop = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

  always_comb begin
    load_out     = !inst_valid_q || !stall_f;
    skid_drain   = load_out && skid_full;
    skid_load    = resp_valid && (!load_out || skid_full);
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (redirect) begin
      inst_valid_d = 1'b0;
    end else if (load_out) begin
      // Skid holds the older word, so it drains first.
      if (skid_full) begin
        inst_valid_d = 1'b1;
        inst_d       = skid_inst;
        inst_pc_d    = skid_pc;
      end else if (resp_valid) begin
        inst_valid_d = 1'b1;
        inst_d       = imem.imem_rdata;
        inst_pc_d    = req_pc_q;
      end else begin
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  if_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .drain   (skid_drain),
    .flush   (redirect),
    .in_inst (imem.imem_rdata),
    .in_pc   (req_pc_q),
    .full    (skid_full),
    .out_inst(skid_inst),
    .out_pc  (skid_pc)
  );

  // Gate with rst so no request is visible while reset is held.
  assign imem.imem_req  = req && rst;
  assign imem.imem_addr = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc_add_4       = inst_pc_q + WIDTH'(32'd4);

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] discard_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      if (inst_valid_q && !stall_f) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (resp_drop) discard_cnt_q <= discard_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt   = fetch_cnt_q;
  assign perf_discard_cnt = discard_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: behavioural memory + fetch-stream model, randomized
// and directed phases, monitor compares every instruction ID accepts.
module tb_if_fetch_ctrl;

  localparam int unsigned W   = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0;
  logic        exc_valid = 1'b0, jump_valid = 1'b0, branch_valid = 1'b0;
  logic [31:0] exc_pc = '0, jump_pc = '0, branch_pc = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, pc_add_4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_discard_cnt;
`endif

  if_fetch_ctrl_if #(.WIDTH(W)) imem ();

  if_fetch_ctrl #(
    .WIDTH   (W),
    .RESET_PC(RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .exc_valid   (exc_valid),
    .exc_pc      (exc_pc),
    .jump_valid  (jump_valid),
    .jump_pc     (jump_pc),
    .branch_valid(branch_valid),
    .branch_pc   (branch_pc),
    .imem        (imem),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_add_4    (pc_add_4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_discard_cnt(perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_bad = 0, n_acc = 0;
  ent_t q[$];
  ent_t mon_x;
  bit   mon_en = 1'b0;

  // Memory / fetch-stream model state.
  bit          outst = 1'b0, stale = 1'b0;
  int          cnt = 0;
  logic [31:0] resp_addr = '0, fp = RPC;
  ent_t        pend;

  // Knobs for the driver.
  int          gnt_pct = 100, stall_pct = 0, redir_pct = 0, lat_min = 1, lat_max = 1;
  int          stall_mode = 2;  // 0 random, 1 force high, 2 force low
  bit          f_exc = 0, f_jump = 0, f_branch = 0, f_gnt = 0;
  logic [31:0] f_exc_pc = '0, f_jump_pc = '0, f_branch_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8;
    return $urandom & 32'h0000_FFFC;
  endfunction

  task automatic step();
    bit          rv, g, e, j, b, st, redir;
    logic [31:0] ep, jp, bp, tgt;
    @(negedge clk);
    rv = outst && (cnt == 0);
    if (outst) chk("one_outstanding_req", 32'(imem.imem_req), 32'd0);
    if (q.size() == 2) chk("req_blocked_skid_full", 32'(imem.imem_req), 32'd0);
    g  = imem.imem_req && (f_gnt || ($urandom_range(0, 99) < gnt_pct));
    e  = f_exc || ($urandom_range(0, 99) < redir_pct);
    j  = f_jump || ($urandom_range(0, 99) < redir_pct);
    b  = f_branch || ($urandom_range(0, 99) < redir_pct);
    ep = f_exc ? f_exc_pc : pick_target();
    jp = f_jump ? f_jump_pc : pick_target();
    bp = f_branch ? f_branch_pc : pick_target();
    st = (stall_mode == 1) || (stall_mode == 0 && $urandom_range(0, 99) < stall_pct);
    stall_f          = st;
    exc_valid        = e;    exc_pc    = ep;
    jump_valid       = j;    jump_pc   = jp;
    branch_valid     = b;    branch_pc = bp;
    imem.imem_gnt    = g;
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rv ? mem_word(resp_addr) : $urandom;
    #2;
    redir = e || j || b;
    tgt   = e ? ep : (j ? jp : bp);
    if (rv) begin
      if (!stale && !redir) q.push_back(pend);
      outst = 1'b0;
    end else if (outst) begin
      cnt--;
      if (redir) stale = 1'b1;
    end
    if (g) begin
      if (!redir) chk("grant_addr", imem.imem_addr, fp);
      pend      = '{pc: fp, ins: mem_word(fp)};
      resp_addr = imem.imem_addr;
      outst     = 1'b1;
      cnt       = $urandom_range(lat_min, lat_max) - 1;
      stale     = redir;
      if (!redir) fp = fp + 32'd4;
    end
    if (redir) begin
      q.delete();
      fp = tgt;
    end
    f_exc = 0; f_jump = 0; f_branch = 0; f_gnt = 0;
  endtask

  task automatic wait_outstanding(input string name);
    int k = 0;
    while (!outst && k < 50) begin
      step();
      k++;
    end
    if (!outst) timeout(name);
  endtask

  task automatic do_reset_mid();
    wait_outstanding("reach_wait_before_reset");
    @(negedge clk);
    stall_f = 0; exc_valid = 0; jump_valid = 0; branch_valid = 0;
    imem.imem_gnt = 0; imem.imem_rvalid = 0;
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_imem_req", 32'(imem.imem_req), 32'd0);
    chk("rst_mid_imem_addr", imem.imem_addr, RPC);
    chk("rst_mid_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_mid_inst", inst, 32'd0);
    chk("rst_mid_inst_pc", inst_pc, 32'd0);
    q.delete();
    outst = 1'b0;
    fp    = RPC;
    n_acc = 0;
    repeat (2) begin
      @(negedge clk);
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
    rst = 1'b1;
  endtask

  // Monitor: compares every word ID accepts against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (inst_valid && !stall_f) begin
          n_acc++;
          if (q.size() > 0) begin
            mon_x = q.pop_front();
            chk("inst_pc", inst_pc, mon_x.pc);
            chk("inst", inst, mon_x.ins);
            chk("pc_add_4", pc_add_4, mon_x.pc + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = '0;
    @(negedge clk);
    #1;
    chk("reset_imem_req", 32'(imem.imem_req), 32'd0);
    chk("reset_imem_addr", imem.imem_addr, RPC);
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_inst_pc", inst_pc, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Back-to-back fetch: gnt immediately, one-cycle latency, no stall.
    repeat (12) step();

    // Hold ID off so the output and skid both fill, then release.
    stall_mode = 1;
    repeat (5) step();
    stall_mode = 2;
    repeat (8) step();

    // Jump while waiting on a 3-cycle response.
    lat_min = 3; lat_max = 3;
    wait_outstanding("reach_wait_for_jump");
    f_jump = 1; f_jump_pc = 32'h0000_0100;
    step();
    repeat (10) step();

    // Exception and branch together: exception wins.
    f_exc = 1; f_exc_pc = 32'h0000_0080;
    f_branch = 1; f_branch_pc = 32'h0000_0200;
    step();
    repeat (10) step();

    // Redirect coincident with a grant.
    lat_min = 2; lat_max = 2; gnt_pct = 0;
    repeat (6) step();
    f_gnt = 1; f_jump = 1; f_jump_pc = 32'h0000_0300;
    step();
    gnt_pct = 100;
    repeat (10) step();

    // Randomized traffic.
    gnt_pct = 60; stall_pct = 30; redir_pct = 2; lat_min = 1; lat_max = 4; stall_mode = 0;
    repeat (3000) step();

    do_reset_mid();
    repeat (500) step();

    // Drain: nothing should be left undelivered.
    redir_pct = 0; stall_mode = 2; gnt_pct = 0;
    repeat (20) step();
    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    #2;
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(n_acc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
